// File: rtl/coalescing_write_buffer.sv
// coalescing_write_buffer
//   Circular write buffer for dirty-victim writebacks. A new write to an
//   address already queued (and not at the head) overwrites that entry's
//   data instead of allocating. The head entry drains to memory whenever
//   no demand-miss read is in progress. Queued data is visible to loads
//   through a combinational lookup port.
//
// Ports
//   clk                      single clock, rising edge
//   n_rst                    asynchronous reset, active HIGH despite the name
//   enq_wen/enq_addr/enq_data  write request
//   miss_ren                 demand miss in progress, holds off draining
//   mem_wait                 memory busy, head is not popped while high
//   mem_wen/mem_addr/mem_data  drain request carrying the head entry
//   lookup_addr/lookup_hit/lookup_data  store-to-load forwarding
//   empty/full/count         occupancy, all from registered state
//   overflow                 one-cycle pulse after a dropped write
module coalescing_write_buffer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       enq_wen,
  input  logic [ADDR_W-1:0]          enq_addr,
  input  logic [DATA_W-1:0]          enq_data,
  input  logic                       miss_ren,
  input  logic                       mem_wait,
  output logic                       mem_wen,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_data,
  input  logic [ADDR_W-1:0]          lookup_addr,
  output logic                       lookup_hit,
  output logic [DATA_W-1:0]          lookup_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;

  logic              pop, alloc, coal;
  logic [PW-1:0]     coal_idx, lk_idx;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign overflow = overflow_q;
  assign mem_wen  = !empty && !miss_ren;
  assign mem_addr = addr_q[head_q];
  assign mem_data = data_q[head_q];
  assign pop      = mem_wen && !mem_wait;

  // The head is excluded from coalescing: it may already be on the memory
  // bus, so its data must not change underneath an in-flight write.
  // Only the head plus one younger entry can share an address, so at most
  // one non-head entry can match here.
  always_comb begin
    coal     = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == enq_addr) && (PW'(i) != head_q)) begin
        coal     = 1'b1;
        coal_idx = PW'(i);
      end
    end
  end

  assign alloc = enq_wen && !coal && !full;

  always_comb begin
    valid_d    = valid_q;
    addr_d     = addr_q;
    data_d     = data_q;
    head_d     = head_q;
    tail_d     = tail_q;
    overflow_d = 1'b0;
    if (enq_wen && coal) begin
      data_d[coal_idx] = enq_data;
    end
    if (alloc) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = enq_addr;
      data_d[tail_q]  = enq_data;
      tail_d          = tail_q + 1'b1;
    end
    // Fullness is judged before this edge's pop, so a write arriving while
    // full is dropped even if a slot frees up on the same edge.
    if (enq_wen && !coal && full) begin
      overflow_d = 1'b1;
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    count_d = count_q + CW'(alloc) - CW'(pop);
  end

  // Walk from head towards tail so the last match seen is the youngest.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lk_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = head_q + PW'(i);
      if (valid_q[lk_idx] && (addr_q[lk_idx] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[lk_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: doc/coalescing_write_buffer.md
COALESCING_WRITE_BUFFER -- requirements
Module: coalescing_write_buffer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 32, data width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 4, entry count (power of two, >=2).
REQ-004 The block SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 The block SHALL have port n_rst, input, 1, asynchronous active-high reset (port keeps codebase name; asserted high clears state).
REQ-006 The block SHALL have port enq_wen, input, 1, dirty-victim write request.
REQ-007 The block SHALL have ports enq_addr, input, ADDR_W, and enq_data, input, DATA_W, the write address and data.
REQ-008 The block SHALL have port miss_ren, input, 1, demand-miss read in progress; blocks drain.
REQ-009 The block SHALL have port mem_wait, input, 1, memory busy; pop only when low.
REQ-010 The block SHALL have ports mem_wen, mem_addr and mem_data, outputs of 1, ADDR_W and DATA_W, the drain request and head entry contents.
REQ-011 The block SHALL have ports lookup_addr, input, ADDR_W; lookup_hit, output, 1; and lookup_data, output, DATA_W, for store-to-load forwarding.
REQ-012 The block SHALL have ports empty, output, 1; full, output, 1; count, output, $clog2(DEPTH)+1; and overflow, output, 1, a one-cycle pulse on a dropped write.

Function
REQ-013 Storage SHALL be a circular buffer of DEPTH entries {valid, addr, data} with head/tail pointers wrapping modulo DEPTH.
REQ-014 mem_wen SHALL equal !empty && !miss_ren, combinationally.
REQ-015 mem_addr/mem_data SHALL show the head entry and stay stable while mem_wen=1 && mem_wait=1.
REQ-016 Pop SHALL occur on a clock edge with mem_wen=1 && mem_wait=0: head invalidated, head+1, count-1.
REQ-017 Coalesce: if enq_wen=1 and enq_addr equals a valid non-head entry, that entry's data SHALL be overwritten; no allocation, count unchanged.
REQ-018 The head entry SHALL never be coalesced into; a write matching only the head allocates a new tail entry.
REQ-019 Allocate: if enq_wen=1, no coalesce, and full=0, the entry SHALL be written at tail, tail+1, count+1.
REQ-020 If enq_wen=1, no coalesce, and full=1, the write SHALL be dropped and overflow pulsed high for exactly the following cycle, even if a pop occurs the same edge.
REQ-021 Simultaneous allocate and pop SHALL leave count unchanged, with both pointers advanced.
REQ-022 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both from registered state.
REQ-023 lookup_hit SHALL be combinational: 1 if any valid entry matches lookup_addr; lookup_data SHALL be the youngest match's data, else 0.
REQ-024 Forwarding SHALL reflect registered state only; a same-cycle enq SHALL NOT forward.
REQ-025 At most one entry SHALL hold any given address, guaranteed by coalescing, except the head plus one younger entry.

Reset
REQ-026 While n_rst=1: all valid bits 0; head=tail=0; count=0; empty=1; full=0; overflow=0; mem_wen=0; lookup_hit=0.
REQ-027 Reset mid-drain SHALL discard all entries immediately, with no pop completion.

Verification
REQ-028 The bench SHALL cover: reset, then enq 0x100/0xA, 0x104/0xB with miss_ren=1 -> count=2, mem_wen=0; drop miss_ren, mem_wait=0 -> 0x100 then 0x104 drained on consecutive edges, then empty=1.
REQ-029 The bench SHALL cover: with entries 0x100, 0x104 queued, enq 0x104/0xC -> count stays 2; drain emits 0x104/0xC.
REQ-030 The bench SHALL cover: with head 0x100 in flight (mem_wait=1), enq 0x100/0xD -> new entry, count+1; head still outputs original data.
REQ-031 The bench SHALL cover: fill DEPTH=4 entries, then enq a new address with simultaneous pop -> write dropped, overflow=1 next cycle, count=3.
REQ-032 The bench SHALL cover: lookup_addr=0x104 with 0x104/0xB queued -> lookup_hit=1, lookup_data=0xB; lookup of an absent address -> hit=0, data=0.
REQ-033 The bench SHALL cover: assert n_rst with 3 entries during mem_wait=1 -> next observation count=0, mem_wen=0, then pointer wrap verified over 2*DEPTH enq/pop cycles.
